serdes_frame_arbiter: RTL and testbench

Shares one `serdes_Deserializer` input among `N_REQ` serial sample streams. The arbiter grants one requester at a time and holds that grant for exactly `N_SAMPLES` accepted beats, so each deserialized frame comes from a single source. It sits directly in front of the deserializer's `recv_*` port. It exports the owning source index so the consumer can tag the parallel frame.

---
 rtl/serdes_frame_arbiter.sv | 153 +++++++++++++++
 tb/tb_serdes_frame_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_frame_arbiter.sv
// -----------------------------------------------------------------------------
// serdes_frame_arbiter
//
// Shares one deserializer input among N_REQ serial sample streams. A requester
// that wins arbitration owns the downstream port for exactly N_SAMPLES accepted
// beats, so every deserialized frame is built from a single source. The current
// owner index is exported on send_src_o so the consumer can tag each frame.
//
// Build option:
//   SERDES_FRAME_ARB_RR_EN  defined   -> round-robin arbitration starting at ptr
//                           undefined -> fixed priority (lowest index wins),
//                                        no priority pointer register
//
// Ports:
//   clk_i       sole clock, rising edge
//   reset_i     synchronous, active-high reset
//   req_val_i   per-requester valid                [N_REQ]
//   req_rdy_o   per-requester ready                [N_REQ]
//   req_msg_i   requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   send_val_o  valid towards deserializer recv_val
//   send_rdy_i  ready from deserializer recv_rdy
//   send_msg_o  sample towards deserializer recv_msg
//   send_src_o  index of the current (or last) owner
//   busy_o      high while a frame is locked
// -----------------------------------------------------------------------------
module serdes_frame_arbiter #(
  parameter int  N_REQ     = 4,
  parameter int  N_SAMPLES = 8,
  parameter int  BIT_WIDTH = 32,
  localparam int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W     = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [N_REQ-1:0]           req_val_i,
  output logic [N_REQ-1:0]           req_rdy_o,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_msg_i,
  output logic                       send_val_o,
  input  logic                       send_rdy_i,
  output logic [BIT_WIDTH-1:0]       send_msg_o,
  output logic [SRC_W-1:0]           send_src_o,
  output logic                       busy_o
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q;
  logic [SRC_W-1:0] grant_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [SRC_W-1:0] win_s;
  logic             any_s;
  logic             fire_s;
  logic             last_beat_s;

`ifdef SERDES_FRAME_ARB_RR_EN
  logic [SRC_W-1:0] ptr_q;
  logic [SRC_W-1:0] ptr_d;
  logic [SRC_W:0]   scan_s;
  logic [SRC_W-1:0] idx_s;

  // Round-robin winner: scan ptr, ptr+1, ... modulo N_REQ. The loop walks the
  // scan order backwards so the earliest asserted position is written last.
  always_comb begin
    win_s  = '0;
    scan_s = '0;
    idx_s  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_s = {1'b0, ptr_q} + (SRC_W+1)'(k);
      idx_s  = SRC_W'((scan_s >= (SRC_W+1)'(N_REQ)) ? (scan_s - (SRC_W+1)'(N_REQ)) : scan_s);
      win_s  = req_val_i[idx_s] ? idx_s : win_s;
    end
  end

  // Pointer moves to the requester after the one whose frame just ended.
  assign ptr_d = (grant_q == SRC_W'(N_REQ - 1)) ? '0 : (grant_q + 1'b1);
`else
  // Fixed priority winner: lowest asserted index, walked backwards so it is
  // the last one written.
  always_comb begin
    win_s = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      win_s = req_val_i[k] ? SRC_W'(k) : win_s;
    end
  end
`endif

  assign any_s       = |req_val_i;
  assign count_d     = count_q + 1'b1;
  assign last_beat_s = (count_q == CNT_W'(N_SAMPLES - 1));
  assign fire_s      = send_val_o & send_rdy_i;

  // Pass-through datapath: the owner's valid/msg go straight downstream and
  // only the owner sees the downstream ready. No beat latency is added.
  always_comb begin
    send_msg_o = req_msg_i[int'(grant_q)*BIT_WIDTH +: BIT_WIDTH];
    send_val_o = 1'b0;
    req_rdy_o  = '0;
    if (state_q == LOCK) begin
      send_val_o         = req_val_i[grant_q];
      req_rdy_o[grant_q] = send_rdy_i;
    end else begin
      send_val_o = 1'b0;
    end
  end

  // Frame FSM: arbitrate in IDLE, count accepted beats in LOCK. A stalled
  // owner keeps the lock indefinitely; there is no preemption.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      count_q <= '0;
`ifdef SERDES_FRAME_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_s) begin
            grant_q <= win_s;
            count_q <= '0;
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (fire_s) begin
            if (last_beat_s) begin
              state_q <= IDLE;
              count_q <= '0;
`ifdef SERDES_FRAME_ARB_RR_EN
              ptr_q   <= ptr_d;
`endif
            end else begin
              count_q <= count_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign send_src_o = grant_q;
  assign busy_o     = (state_q == LOCK);

endmodule

// File: tb/tb_serdes_frame_arbiter.sv
module tb_serdes_frame_arbiter;

  localparam int BW = 32;

  logic         clk = 1'b0;
  logic         rst;
  // default-parameter instance (N_REQ=4, N_SAMPLES=8)
  logic [3:0]   val, rrdy;
  logic [127:0] msg;
  logic         rdy, sval, busy;
  logic [31:0]  smsg;
  logic [1:0]   src;
  // edge-parameter instance (N_REQ=3, N_SAMPLES=1)
  logic [2:0]   val3, rrdy3;
  logic [95:0]  msg3;
  logic         rdy3, sval3, busy3;
  logic [31:0]  smsg3;
  logic [1:0]   src3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serdes_frame_arbiter #(.N_REQ(4), .N_SAMPLES(8), .BIT_WIDTH(BW)) dut (
    .clk_i(clk), .reset_i(rst), .req_val_i(val), .req_rdy_o(rrdy), .req_msg_i(msg),
    .send_val_o(sval), .send_rdy_i(rdy), .send_msg_o(smsg), .send_src_o(src), .busy_o(busy));

  serdes_frame_arbiter #(.N_REQ(3), .N_SAMPLES(1), .BIT_WIDTH(BW)) dut3 (
    .clk_i(clk), .reset_i(rst), .req_val_i(val3), .req_rdy_o(rrdy3), .req_msg_i(msg3),
    .send_val_o(sval3), .send_rdy_i(rdy3), .send_msg_o(smsg3), .send_src_o(src3), .busy_o(busy3));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit locked;
    int grant;
    int beats;
    int ptr;
  } mdl_t;

  function automatic int pick(mdl_t m, int n, logic [3:0] v);
    int w = -1;
    for (int k = 0; k < n; k++) begin
`ifdef SERDES_FRAME_ARB_RR_EN
      if (w < 0 && v[(m.ptr + k) % n]) w = (m.ptr + k) % n;
`else
      if (w < 0 && v[k]) w = k;
`endif
    end
    return w;
  endfunction

  function automatic mdl_t advance(mdl_t m, int n, int ns, logic r, logic [3:0] v, logic rd);
    mdl_t q = m;
    int w;
    if (r) begin
      q = '{locked: 1'b0, grant: 0, beats: 0, ptr: 0};
    end else if (!m.locked) begin
      w = pick(m, n, v);
      if (w >= 0) begin
        q.locked = 1'b1;
        q.grant  = w;
        q.beats  = 0;
      end
    end else if (v[m.grant] && rd) begin
      q.beats = m.beats + 1;
      if (q.beats == ns) begin
        q.locked = 1'b0;
        q.beats  = 0;
        q.ptr    = (m.grant + 1) % n;
      end
    end
    return q;
  endfunction

  task automatic check_cycle(input string tag, input mdl_t m, input logic [3:0] v,
                             input logic [127:0] mg, input logic rd, input logic a_busy,
                             input logic [1:0] a_src, input logic a_sval,
                             input logic [3:0] a_rrdy, input logic [31:0] a_msg);
    logic [3:0] e_rrdy = 4'b0;
    if (m.locked) e_rrdy[m.grant] = rd;
    chk({tag, ".busy"}, 64'(a_busy), 64'(m.locked));
    chk({tag, ".src"}, 64'(a_src), 64'(m.grant));
    chk({tag, ".send_val"}, 64'(a_sval), 64'(m.locked && v[m.grant]));
    chk({tag, ".req_rdy"}, 64'(a_rrdy), 64'(e_rrdy));
    if (m.locked) chk({tag, ".send_msg"}, 64'(a_msg), 64'(mg[m.grant*32 +: 32]));
  endtask

  task automatic do_reset();
    rst = 1'b1; val = 4'b0; rdy = 1'b0; val3 = 3'b0; rdy3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] val;
    logic       rdy;
    logic       busy;
    logic [1:0] src;
    logic       sval;
    logic [3:0] rrdy;
  } vec_t;

  vec_t tbl[12];

  int   exp_own[5];
  int   own_n, fires, first_c, cyc;
  logic prev_busy, started, done;
  mdl_t m4, m3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   val    rdy   busy  src   sval  rrdy
    tbl[0]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[2]  = '{1'b0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[3]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[4]  = '{1'b0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1, 4'h0};
    tbl[5]  = '{1'b0, 4'hE, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1};
    tbl[6]  = '{1'b0, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[7]  = '{1'b1, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[9]  = '{1'b0, 4'h8, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0};
    tbl[10] = '{1'b0, 4'h8, 1'b1, 1'b1, 2'd3, 1'b1, 4'h8};
    tbl[11] = '{1'b0, 4'h8, 1'b0, 1'b1, 2'd3, 1'b1, 4'h0};

    rst = 1'b1; val = 4'h0; msg = '0; rdy = 1'b0;
    val3 = 3'b0; msg3 = '0; rdy3 = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; val = tbl[i].val; rdy = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d.busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d.src", i), 64'(src), 64'(tbl[i].src));
      chk($sformatf("tbl%0d.send_val", i), 64'(sval), 64'(tbl[i].sval));
      chk($sformatf("tbl%0d.req_rdy", i), 64'(rrdy), 64'(tbl[i].rrdy));
      @(posedge clk); #1;
    end

    // Single requester 2 streams 0x10..0x17 without stalls
    do_reset();
    val = 4'b0100; rdy = 1'b1; fires = 0; first_c = -1;
    msg[64 +: 32] = 32'h10;
    for (int c = 0; c < 20 && fires < 8; c++) begin
      @(negedge clk);
      if (sval && rdy) begin
        if (first_c < 0) first_c = c;
        chk("single.msg", 64'(smsg), 64'(32'h10 + fires));
        chk("single.src", 64'(src), 64'd2);
        fires++;
      end
      @(posedge clk); #1;
      msg[64 +: 32] = 32'h10 + fires;
    end
    chk("single.fires", 64'(fires), 64'd8);
    chk("single.first_fire_cycle", 64'(first_c), 64'd1);
    @(negedge clk);
    chk("single.bubble", 64'(busy), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single.relock", 64'(busy), 64'd1);
    chk("single.relock_src", 64'(src), 64'd2);

    // Contention: all four requesters continuously valid
    do_reset();
`ifdef SERDES_FRAME_ARB_RR_EN
    exp_own = '{0, 1, 2, 3, 0};
`else
    exp_own = '{0, 0, 0, 0, 0};
`endif
    val = 4'hF; rdy = 1'b1; own_n = 0; prev_busy = 1'b0;
    for (int c = 0; c < 100 && own_n < 5; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        chk($sformatf("contend.owner%0d", own_n), 64'(src), 64'(exp_own[own_n]));
        own_n++;
      end
      prev_busy = busy;
      @(posedge clk); #1;
    end
    chk("contend.frames", 64'(own_n), 64'd5);

    // Stalls: ready pattern 1,0,0,1 and owner drops valid for 3 cycles
    do_reset();
    fires = 0; started = 1'b0; done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      rdy = (c % 4 == 0) || (c % 4 == 3);
      val = (c >= 6 && c <= 8) ? 4'b1000 : 4'b1010;
      @(negedge clk);
      if (busy) begin
        started = 1'b1;
        chk("stall.src", 64'(src), 64'd1);
        chk("stall.others_rdy", 64'(rrdy & 4'b1101), 64'd0);
        chk("stall.send_val", 64'(sval), 64'(val[1]));
        if (sval && rdy) fires++;
      end else if (started) begin
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("stall.ended", 64'(done), 64'd1);
    chk("stall.fires", 64'(fires), 64'd8);

    // Reset after the 5th beat of requester 1
    do_reset();
    val = 4'b0010; rdy = 1'b1; fires = 0;
    for (int c = 0; c < 20 && fires < 5; c++) begin
      @(negedge clk);
      if (sval && rdy) fires++;
      @(posedge clk); #1;
    end
    chk("midrst.fires_before", 64'(fires), 64'd5);
    rst = 1'b1; val = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.idle", 64'(busy), 64'd0);
    chk("midrst.src", 64'(src), 64'd0);
    @(posedge clk); #1;
    fires = 0; done = 1'b0;
    @(negedge clk);
    chk("midrst.newowner", 64'(src), 64'd0);
    for (int c = 0; c < 20 && !done; c++) begin
      if (!busy) done = 1'b1;
      else if (sval && rdy) fires++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("midrst.new_frame_fires", 64'(fires), 64'd8);

    // Edge parameters N_REQ=3, N_SAMPLES=1, all valid
    do_reset();
    val3 = 3'b111; rdy3 = 1'b1; own_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("edge.busy%0d", c), 64'(busy3), 64'(c % 2));
      if (c % 2 == 1) begin
        chk("edge.send_val", 64'(sval3), 64'd1);
`ifdef SERDES_FRAME_ARB_RR_EN
        chk($sformatf("edge.owner%0d", own_n), 64'(src3), 64'(own_n % 3));
`else
        chk($sformatf("edge.owner%0d", own_n), 64'(src3), 64'd0);
`endif
        own_n++;
      end
      @(posedge clk); #1;
    end

    // Randomized run against the reference model, both instances
    do_reset();
    m4 = '{locked: 1'b0, grant: 0, beats: 0, ptr: 0};
    m3 = m4;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(99) == 0);
      val  = 4'($urandom);
      rdy  = ($urandom_range(3) != 0);
      msg  = {$urandom, $urandom, $urandom, $urandom};
      val3 = 3'($urandom);
      rdy3 = ($urandom_range(3) != 0);
      msg3 = {$urandom, $urandom, $urandom};
      @(negedge clk);
      check_cycle("rnd4", m4, val, msg, rdy, busy, src, sval, rrdy, smsg);
      check_cycle("rnd3", m3, {1'b0, val3}, {32'b0, msg3}, rdy3, busy3, src3, sval3,
                  {1'b0, rrdy3}, smsg3);
      m4 = advance(m4, 4, 8, rst, val, rdy);
      m3 = advance(m3, 3, 1, rst, {1'b0, val3}, rdy3);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
